// File: rtl/game_ctrl.sv
// game_ctrl: asteroid game sequencer (title/play/respawn/game-over), lives, saturating score, invulnerability.
// Latency: buttons 2 clk sync then next pixpulse edge; collision/score to state/lives/score/hit on the next pixpulse edge.
// Backpressure: none; every input is sampled on pixpulse and nothing stalls the sequencer.
//
// Ports:
//   clk, rst                  100 MHz clock, asynchronous active-high reset
//   pixpulse                  1-in-4 clock enable qualifying every state update
//   frame_tick                one-pixpulse pulse at vblank start
//   move_up/down/left/right   raw asynchronous buttons (synchronized here)
//   collision[4:0]            per-asteroid ship overlap levels
//   score_inc[4:0]            per-asteroid one-pixpulse score pulses
//   state[1:0]                00 TITLE, 01 PLAY, 10 GAME_OVER, 11 RESPAWN
//   obj_rst                   playfield object reset (TITLE, GAME_OVER)
//   move_en                   per-frame motion enable (PLAY, RESPAWN)
//   lives[1:0], score[8:0]    remaining lives, current score
//   hit                       one-pixpulse pulse when a life is lost
//   ship_visible              ship draw enable, blinking during RESPAWN
`timescale 1ns/1ps
module game_ctrl #(
    parameter int LIVES            = 3,
    parameter int INVULN_FRAMES    = 120,
    parameter int SCORE_MAX        = 255,
    parameter int OVER_HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic       frame_tick,
    input  logic       move_up,
    input  logic       move_down,
    input  logic       move_left,
    input  logic       move_right,
    input  logic [4:0] collision,
    input  logic [4:0] score_inc,
    output logic [1:0] state,
    output logic       obj_rst,
    output logic       move_en,
    output logic [1:0] lives,
    output logic [8:0] score,
    output logic       hit,
    output logic       ship_visible
);

    typedef enum logic [1:0] {
        ST_TITLE   = 2'b00,
        ST_PLAY    = 2'b01,
        ST_OVER    = 2'b10,
        ST_RESPAWN = 2'b11
    } state_t;

    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
    localparam logic [8:0] SCORE_CAP   = 9'(SCORE_MAX);
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0] OVER_HOLD   = 8'(OVER_HOLD_FRAMES);

    state_t     cur_state, nxt_state;
    logic [3:0] btn_meta, btn_sync;
    logic       btn_or_d;
    logic       coll_d;
    logic [7:0] frame_cnt, frame_cnt_nxt;
    logic [1:0] lives_nxt;
    logic [8:0] score_nxt;
    logic       hit_nxt;

    logic       any_rise, all_held, new_hit;
    logic [2:0] inc_cnt;
    logic [9:0] score_sum;
    logic [8:0] score_clamped;
    logic       score_full;

    // Two-flop synchronizer runs every clk, independent of pixpulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {move_right, move_left, move_down, move_up};
            btn_sync <= btn_meta;
        end
    end

    assign any_rise = (|btn_sync) & ~btn_or_d;
    assign all_held = &btn_sync;
    // coll_d tracks in every state, so a collision still held when
    // RESPAWN ends is not seen as a fresh edge.
    assign new_hit  = (|collision) & ~coll_d;

    // Score adder: 3-bit popcount, 10-bit sum, clamp to the cap.
    always_comb begin
        inc_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            inc_cnt = inc_cnt + {2'b00, score_inc[i]};
        end
        score_sum     = {1'b0, score} + {7'd0, inc_cnt};
        score_clamped = (score_sum > {1'b0, SCORE_CAP}) ? SCORE_CAP : score_sum[8:0];
        score_full    = (score_clamped >= SCORE_CAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_TITLE;
            lives     <= LIVES_INIT;
            score     <= '0;
            hit       <= 1'b0;
            frame_cnt <= '0;
            coll_d    <= 1'b0;
            btn_or_d  <= 1'b0;
        end else if (pixpulse) begin
            cur_state <= nxt_state;
            lives     <= lives_nxt;
            score     <= score_nxt;
            hit       <= hit_nxt;
            frame_cnt <= frame_cnt_nxt;
            coll_d    <= |collision;
            btn_or_d  <= |btn_sync;
        end
    end

    always_comb begin
        nxt_state     = cur_state;
        lives_nxt     = lives;
        score_nxt     = score;
        hit_nxt       = 1'b0;
        frame_cnt_nxt = frame_cnt;
        case (cur_state)
            ST_TITLE: begin
                lives_nxt = LIVES_INIT;
                score_nxt = '0;
                if (any_rise) begin
                    nxt_state = ST_PLAY;
                end
            end
            ST_PLAY, ST_RESPAWN: begin
                score_nxt = score_clamped;
                if (cur_state == ST_PLAY) begin
                    // A hit outranks any button activity in the same pixpulse.
                    if (new_hit) begin
                        hit_nxt = 1'b1;
                        if (lives != 2'd0) begin
                            lives_nxt = lives - 2'd1;
                        end
                        if (lives <= 2'd1) begin
                            nxt_state = ST_OVER;
                        end else begin
                            nxt_state     = ST_RESPAWN;
                            frame_cnt_nxt = '0;
                        end
                    end
                end else if (frame_tick) begin
                    if (frame_cnt == INVULN_LAST) begin
                        nxt_state     = ST_PLAY;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
                // Saturation ends the game regardless of hit/respawn outcome.
                if (score_full) begin
                    nxt_state = ST_OVER;
                end
                if (nxt_state == ST_OVER) begin
                    frame_cnt_nxt = '0;
                end
            end
            ST_OVER: begin
                if (all_held && (frame_cnt >= OVER_HOLD)) begin
                    nxt_state     = ST_TITLE;
                    lives_nxt     = LIVES_INIT;
                    score_nxt     = '0;
                    frame_cnt_nxt = '0;
                end else if (frame_tick && (frame_cnt != 8'hFF)) begin
                    frame_cnt_nxt = frame_cnt + 8'd1;
                end
            end
            default: begin
                nxt_state = ST_TITLE;
            end
        endcase
    end

    assign state        = cur_state;
    assign obj_rst      = (cur_state == ST_TITLE) | (cur_state == ST_OVER);
    assign move_en      = frame_tick & pixpulse & ((cur_state == ST_PLAY) | (cur_state == ST_RESPAWN));
    assign ship_visible = (cur_state == ST_RESPAWN) ? ~frame_cnt[3] : 1'b1;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl (table vectors, directed corner sequences, random vs reference model).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_game_ctrl;
    localparam int LIVES   = 3;
    localparam int INVULN  = 120;
    localparam int SMAX    = 255;
    localparam int HOLD    = 60;
    localparam int S_TITLE = 0;
    localparam int S_PLAY  = 1;
    localparam int S_OVER  = 2;
    localparam int S_RESP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       move_up, move_down, move_left, move_right;
    logic [4:0] collision = 5'b0;
    logic [4:0] score_inc = 5'b0;
    logic [1:0] state;
    logic       obj_rst, move_en, hit, ship_visible;
    logic [1:0] lives;
    logic [8:0] score;

    assign {move_right, move_left, move_down, move_up} = btn;

    game_ctrl #(.LIVES(LIVES), .INVULN_FRAMES(INVULN), .SCORE_MAX(SMAX), .OVER_HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .frame_tick(frame_tick),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .collision(collision), .score_inc(score_inc), .state(state), .obj_rst(obj_rst),
        .move_en(move_en), .lives(lives), .score(score), .hit(hit), .ship_visible(ship_visible)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hit pulse counter (rising edges of hit).
    int   hit_total = 0;
    logic hit_q = 1'b0;
    always @(posedge clk) begin
        if (hit === 1'b1 && hit_q !== 1'b1) hit_total <= hit_total + 1;
        hit_q <= hit;
    end

    // Reference model: game rules with plain integers.
    int         m_state, m_lives, m_score, m_fc;
    bit         m_hit, m_btn_any_prev, m_coll_prev;
    logic [3:0] seen_1, seen_2;   // raw buttons one and two edges ago
    int         phase;

    task automatic model_reset();
        m_state = S_TITLE; m_lives = LIVES; m_score = 0; m_fc = 0; m_hit = 0;
        m_btn_any_prev = 0; m_coll_prev = 0; seen_1 = 4'b0; seen_2 = 4'b0;
    endtask

    task automatic model_edge();
        logic [3:0] b;
        bit rise, held, fresh;
        int nxt;
        // Logic sees the buttons as they were two clocks back.
        b = seen_2; seen_2 = seen_1; seen_1 = btn;
        if (pixpulse !== 1'b1) return;
        rise  = (b != 4'b0) && !m_btn_any_prev;
        held  = (b == 4'hF);
        fresh = (collision != 5'b0) && !m_coll_prev;
        m_btn_any_prev = (b != 4'b0);
        m_coll_prev    = (collision != 5'b0);
        m_hit = 0;
        if (m_state == S_TITLE) begin
            m_lives = LIVES; m_score = 0;
            if (rise) m_state = S_PLAY;
        end else if (m_state == S_OVER) begin
            if (held && m_fc >= HOLD) begin
                m_state = S_TITLE; m_lives = LIVES; m_score = 0; m_fc = 0;
            end else if (frame_tick && m_fc < 255) begin
                m_fc++;
            end
        end else begin
            m_score = m_score + $countones(score_inc);
            if (m_score > SMAX) m_score = SMAX;
            nxt = m_state;
            if (m_state == S_PLAY && fresh) begin
                m_hit = 1;
                if (m_lives > 0) m_lives--;
                nxt = (m_lives == 0) ? S_OVER : S_RESP;
                if (nxt == S_RESP) m_fc = 0;
            end else if (m_state == S_RESP && frame_tick) begin
                if (m_fc == INVULN - 1) begin
                    nxt = S_PLAY; m_fc = 0;
                end else begin
                    m_fc++;
                end
            end
            if (m_score >= SMAX) nxt = S_OVER;
            if (nxt == S_OVER) m_fc = 0;
            m_state = nxt;
        end
    endtask

    task automatic compare_all();
        check("state", state, m_state);
        check("lives", lives, m_lives);
        check("score", score, m_score);
        check("hit", hit, m_hit);
        check("obj_rst", obj_rst, (m_state == S_TITLE || m_state == S_OVER) ? 1 : 0);
        check("ship_visible", ship_visible, (m_state == S_RESP) ? (((m_fc / 8) % 2 == 0) ? 1 : 0) : 1);
    endtask

    // One clk: called at posedge+1, checks move_en before the edge, the rest after.
    task automatic run_clk();
        pixpulse = (phase == 3);
        #1;
        check("move_en", move_en,
              (frame_tick && pixpulse && (m_state == S_PLAY || m_state == S_RESP)) ? 1 : 0);
        @(posedge clk);
        model_edge();
        phase = (phase + 1) % 4;
        #1;
        compare_all();
    endtask

    task automatic pp_step(input logic ft);
        frame_tick = ft;
        do run_clk(); while (phase != 0);
        frame_tick = 1'b0;
    endtask

    task automatic frame_step();
        pp_step(1'b1);
        pp_step(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = 4'b0; collision = 5'b0; score_inc = 5'b0;
        pixpulse = 1'b1; frame_tick = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, S_TITLE);
        check("rst_lives", lives, LIVES);
        check("rst_score", score, 0);
        check("rst_hit", hit, 0);
        check("rst_ship_visible", ship_visible, 1);
        check("rst_obj_rst", obj_rst, 1);
        check("rst_move_en", move_en, 0);
        rst = 1'b0; pixpulse = 1'b0; frame_tick = 1'b0; phase = 0;
    endtask

    task automatic start_game();
        btn = 4'b0001;
        pp_step(1'b0);
        btn = 4'b0000;
        check("start_state", state, S_PLAY);
    endtask

    typedef struct {
        logic [3:0] b;
        logic [4:0] coll;
        logic [4:0] inc;
        logic       ft;
        logic [1:0] st;
        logic [1:0] lv;
        logic [8:0] sc;
        logic       h;
    } vec_t;
    vec_t tbl [8];

    int cnt, k;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Each row is held for one pixpulse period, then compared.
        tbl[0] = '{4'b0001, 5'b00000, 5'b00000, 1'b0, 2'd1, 2'd3, 9'd0,  1'b0};
        tbl[1] = '{4'b0001, 5'b00000, 5'b00011, 1'b0, 2'd1, 2'd3, 9'd2,  1'b0};
        tbl[2] = '{4'b0000, 5'b00000, 5'b10101, 1'b0, 2'd1, 2'd3, 9'd5,  1'b0};
        tbl[3] = '{4'b0000, 5'b00100, 5'b00000, 1'b0, 2'd3, 2'd2, 9'd5,  1'b1};
        tbl[4] = '{4'b0000, 5'b00100, 5'b00001, 1'b0, 2'd3, 2'd2, 9'd6,  1'b0};
        tbl[5] = '{4'b1111, 5'b00000, 5'b11111, 1'b1, 2'd3, 2'd2, 9'd11, 1'b0};
        tbl[6] = '{4'b1111, 5'b01000, 5'b00000, 1'b0, 2'd3, 2'd2, 9'd11, 1'b0};
        tbl[7] = '{4'b0000, 5'b00000, 5'b00110, 1'b0, 2'd3, 2'd2, 9'd13, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            btn = tbl[i].b; collision = tbl[i].coll; score_inc = tbl[i].inc;
            pp_step(tbl[i].ft);
            check($sformatf("tbl%0d_state", i), state, int'(tbl[i].st));
            check($sformatf("tbl%0d_lives", i), lives, int'(tbl[i].lv));
            check($sformatf("tbl%0d_score", i), score, int'(tbl[i].sc));
            check($sformatf("tbl%0d_hit", i), hit, int'(tbl[i].h));
        end

        // Button-to-PLAY latency at each pixpulse phase, 10-clk pulse.
        for (int p = 0; p < 4; p++) begin
            do_reset();
            repeat (p) run_clk();
            btn = 4'b0100;
            cnt = 0;
            while (state !== 2'b01 && cnt < 20) begin
                if (cnt == 10) btn = 4'b0;
                run_clk();
                cnt++;
            end
            check($sformatf("latency_p%0d_in_2_to_6", p), (cnt >= 2 && cnt <= 6) ? 1 : 0, 1);
            while (cnt < 10) begin run_clk(); cnt++; end
            btn = 4'b0;
            check("lat_lives", lives, 3);
            check("lat_score", score, 0);
            check("lat_obj_rst", obj_rst, 0);
        end

        // Held collision: one hit, invulnerability blink, no loss on return.
        do_reset();
        start_game();
        k = hit_total;
        collision = 5'b00100;
        pp_step(1'b0);
        check("inv_hit", hit, 1);
        check("inv_lives", lives, 2);
        check("inv_state", state, S_RESP);
        for (int f = 1; f <= INVULN; f++) begin
            frame_step();
            if (f < INVULN) begin
                check("inv_still_resp", state, S_RESP);
                check("inv_blink", ship_visible, ((f / 8) % 2 == 0) ? 1 : 0);
            end else begin
                check("inv_back_play", state, S_PLAY);
            end
        end
        repeat (4) pp_step(1'b0);
        check("inv_no_loss", lives, 2);
        check("inv_state_play", state, S_PLAY);
        check("inv_one_pulse", hit_total - k, 1);

        // Remaining lives to zero; score frozen in GAME_OVER.
        collision = 5'b0; pp_step(1'b0);
        collision = 5'b00001; pp_step(1'b0);
        check("h2_lives", lives, 1);
        check("h2_state", state, S_RESP);
        for (int f = 0; f < INVULN; f++) frame_step();
        check("h2_back_play", state, S_PLAY);
        collision = 5'b0; pp_step(1'b0);
        collision = 5'b00010; pp_step(1'b0);
        check("h3_lives", lives, 0);
        check("h3_state", state, S_OVER);
        check("h3_obj_rst", obj_rst, 1);
        check("h3_hit", hit, 1);
        collision = 5'b0; score_inc = 5'b11111;
        for (int f = 0; f < 260; f++) frame_step();
        check("over_score_frozen", score, 0);
        check("over_lives_zero", lives, 0);
        score_inc = 5'b0; btn = 4'hF;
        pp_step(1'b0);
        check("over_sat_exit", state, S_TITLE);
        pp_step(1'b0);
        check("title_lives", lives, 3);
        check("title_score", score, 0);

        // Score saturation from 250, then exit blocked by a released button.
        do_reset();
        start_game();
        score_inc = 5'b11111;
        repeat (50) pp_step(1'b0);
        check("sat_250", score, 250);
        check("sat_250_state", state, S_PLAY);
        pp_step(1'b0);
        check("sat_255", score, 255);
        check("sat_state_over", state, S_OVER);
        score_inc = 5'b0;
        btn = 4'hF;
        repeat (59) frame_step();
        check("hold59_state", state, S_OVER);
        btn = 4'b1110;
        repeat (5) frame_step();
        check("release_blocks", state, S_OVER);
        btn = 4'hF;
        pp_step(1'b0);
        check("rehold_exit", state, S_TITLE);

        // Exit exactly after the 60th frame_tick.
        btn = 4'b0; pp_step(1'b0);
        start_game();
        score_inc = 5'b11111;
        repeat (51) pp_step(1'b0);
        check("sat2_state", state, S_OVER);
        score_inc = 5'b0;
        btn = 4'hF;
        for (int f = 1; f <= HOLD; f++) begin
            frame_step();
            check($sformatf("hold_f%0d", f), state, (f < HOLD) ? S_OVER : S_TITLE);
        end
        btn = 4'b0;

        // Asynchronous reset between pixpulses while in RESPAWN with hit high.
        do_reset();
        start_game();
        collision = 5'b00100;
        pp_step(1'b0);
        check("ar_pre_hit", hit, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_state", state, S_TITLE);
        check("ar_lives", lives, 3);
        check("ar_hit", hit, 0);
        check("ar_ship_visible", ship_visible, 1);
        check("ar_obj_rst", obj_rst, 1);

        // Random play against the reference model.
        do_reset();
        for (int s = 0; s < 4000; s++) begin
            if ($urandom_range(0, 29) == 0)
                collision = ($urandom_range(0, 1) == 0) ? 5'b0 : 5'($urandom_range(1, 31));
            score_inc = 5'b0;
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 15) == 0) score_inc[b] = 1'b1;
            frame_tick = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 24) == 0) begin
                    k = int'($urandom_range(0, 3));
                    btn[k] = ~btn[k];
                end
                if ($urandom_range(0, 299) == 0) btn = 4'hF;
                run_clk();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
